ddr3_wr_packer: RTL and testbench
=================================

// Module: ddr3_wr_packer
// PURPOSE
//  Upstream feeder of the DDR3 controller write port. Packs a 16-bit sample stream (UDP payload
//  side) into 128-bit words and buffers them in a FWFT FIFO. Raises ddr3_wr_req only when a whole
//  burst is buffered, pops one word per ddr3_wr_ack, and pulses ddr3_wr_load at each frame start.
// PARAMETERS
//  DATA_WD      16  input sample width
//  DQ_WIDTH     16  DDR DQ width; word width = 8*DQ_WIDTH (128)
//  BURST_WORDS  16  words per controller write burst (burst_number 15 -> 16 beats)
//  FIFO_DEPTH   64  word FIFO depth; power of 2, >= 2*BURST_WORDS
// PORTS
//  clk_ref        in   1                 single clock, same as the controller
//  rst_n          in   1                 synchronous, active-low reset
//  s_valid        in   1                 input sample valid
//  s_ready        out  1                 sample accepted when s_valid && s_ready
//  s_data         in   DATA_WD           sample
//  s_sof          in   1                 qualifies the first sample of a frame
//  s_eof          in   1                 qualifies the last sample of a frame
//  ddr3_wr_req    out  1                 >= BURST_WORDS words buffered
//  ddr3_wr_ack    in   1                 pop strobe; ddr3_din is consumed this cycle
//  ddr3_wr_load   out  1                 1-cycle pulse: controller resets its write address
//  ddr3_din       out  8*DQ_WIDTH        FIFO head word, FWFT
//  fifo_level     out  $clog2(DEPTH)+1   words buffered
//  err_sof_mid    out  1                 sticky: SOF arrived with a partial word pending
//  err_underflow  out  1                 sticky: ack received while FIFO empty
// BEHAVIOUR
//  Reset (rst_n=0 at a clk_ref edge): FIFO pointers, lane index, burst counter, and both error flags
//   cleared; state PACK; all outputs 0. Reset mid-burst discards buffered data without a load pulse.
//  Packing: LANES = 8*DQ_WIDTH/DATA_WD (8). Sample k of a word goes to bits [16k+15:16k], so the
//   first sample is at [15:0]. The word is pushed in the cycle its 8th sample is accepted.
//  s_ready = (state==PACK) && !(lane==LANES-1 && full) && !(s_valid && s_sof && !sof_seen).
//   sof_seen is set on entering LOAD and cleared when the SOF sample is accepted.
//  ddr3_din: head word, valid whenever level>0 with no added latency. Shows 0 when empty.
//  ddr3_wr_req = (level >= BURST_WORDS). This is combinational from registered level, because the
//   controller may ack in the same cycle as req.
//  Pop on ddr3_wr_ack && level>0. If ack arrives while empty, set err_underflow; no pointer change.
//  Simultaneous push and pop: level unchanged. Pointers wrap modulo FIFO_DEPTH.
//  burst_cnt counts pushes modulo BURST_WORDS.
//  FSM:
//   PACK  Accept samples. On an accepted EOF sample: go to PADW if lane!=LANES-1, else to PADB.
//         On s_valid && s_sof (not yet sof_seen): if lane!=0, set err_sof_mid and go to PADW
//         (implicit EOF); else go to DRAIN.
//   PADW  When !full: push the partial word with zero-filled upper lanes, clear lane, go to PADB.
//   PADB  While burst_cnt!=0: push one zero word per cycle when !full. At 0: go to DRAIN if a SOF
//         is pending, else to PACK.
//   DRAIN Hold s_ready=0 until level==0, then go to LOAD.
//   LOAD  ddr3_wr_load=1 for exactly 1 cycle; set sof_seen; go to PACK.
//  Padding guarantees every frame occupies an integer number of bursts. The controller never
//   stalls mid-burst on an empty FIFO.
// CONFIGURATION
//  DDR3_WR_PACK_LANE_SWAP_EN defined: lane order reversed; sample 0 at [127:112], sample 7 at
//   [15:0]. This matches 16-bit big-endian column order. Padding zeros occupy the low lanes instead.
//  Not defined: order as above (sample 0 at [15:0]). No other behaviour differs.
// STRUCTURE
//  ddr3_pkg: WR_LANES, the FSM state encoding (PACK, PADW, PADB, DRAIN, LOAD), and a
//   level-width function. The package is shared with the read-side unpacker.
//  Sub-module ddr3_wr_fifo: single-clock FWFT FIFO (push, pop, dout, level, full, empty).
//   It is instantiated once. The packer FSM and lane shift register stay in ddr3_wr_packer.
// TESTING
//  1. SOF + 128 samples 0..127 + EOF -> one load pulse, then 16 words. Word0 = {7,6,..,0}
//     (swap off). req rises when level hits 16; 16 acks drain to level 0.
//  2. Frame of 20 samples -> word2 = {0,0,0,0,19,18,17,16}, then 13 zero words. Total 16 pushes,
//     req asserted once.
//  3. Backpressure: no acks, stream 600 samples -> level saturates at 64. s_ready drops on the
//     lane-7 sample while full; no sample is lost or duplicated after acks resume.
//  4. SOF after 3 samples of a word -> err_sof_mid=1, word padded, burst padded. Then drain, one
//     load pulse, and the new frame's sample 0 lands in lane 0 of the next word.
//  5. Ack with level 0 -> err_underflow=1, level stays 0. rst_n low for 1 cycle mid-burst ->
//     level=0, req=0, flags cleared, next SOF issues a load.
//  6. Rebuild with DDR3_WR_PACK_LANE_SWAP_EN and rerun test 1 -> word0 = {0,1,..,7}.

Source files
------------

// File: rtl/ddr3_pkg.sv
// Shared DDR3 write/read-path definitions: lane geometry, packer FSM encoding,
// and a helper for FIFO level widths.
package ddr3_pkg;

  localparam int unsigned WR_DATA_WD     = 16;
  localparam int unsigned WR_DQ_WIDTH    = 16;
  localparam int unsigned WR_BURST_WORDS = 16;
  localparam int unsigned WR_FIFO_DEPTH  = 64;
  localparam int unsigned WR_LANES       = (8 * WR_DQ_WIDTH) / WR_DATA_WD;

  typedef enum logic [2:0] {
    PACK  = 3'd0,
    PADW  = 3'd1,
    PADB  = 3'd2,
    DRAIN = 3'd3,
    LOAD  = 3'd4
  } wr_state_e;

  // Level counter needs one extra bit so a full FIFO is representable.
  function automatic int unsigned level_wd(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ddr3_wr_packer_if.sv
// Sample-stream and controller write-port bundle for ddr3_wr_packer.
// master: sample source + DDR3 controller side; slave: the packer.
interface ddr3_wr_packer_if #(
  parameter int unsigned DATA_WD    = 16,
  parameter int unsigned DQ_WIDTH   = 16,
  parameter int unsigned FIFO_DEPTH = 64
);
  import ddr3_pkg::*;

  localparam int unsigned WORD_WD = 8 * DQ_WIDTH;
  localparam int unsigned LVL_WD  = level_wd(FIFO_DEPTH);

  logic               s_valid;
  logic               s_ready;
  logic [DATA_WD-1:0] s_data;
  logic               s_sof;
  logic               s_eof;
  logic               ddr3_wr_req;
  logic               ddr3_wr_ack;
  logic               ddr3_wr_load;
  logic [WORD_WD-1:0] ddr3_din;
  logic [LVL_WD-1:0]  fifo_level;
  logic               err_sof_mid;
  logic               err_underflow;

  modport master (
    output s_valid, s_data, s_sof, s_eof, ddr3_wr_ack,
    input  s_ready, ddr3_wr_req, ddr3_wr_load, ddr3_din, fifo_level,
           err_sof_mid, err_underflow
  );

  modport slave (
    input  s_valid, s_data, s_sof, s_eof, ddr3_wr_ack,
    output s_ready, ddr3_wr_req, ddr3_wr_load, ddr3_din, fifo_level,
           err_sof_mid, err_underflow
  );

endinterface

// File: rtl/ddr3_wr_fifo.sv
// Single-clock first-word-fall-through word FIFO; head word visible with no
// read latency, zero when empty. Pushes while full and pops while empty are ignored.
module ddr3_wr_fifo
  import ddr3_pkg::*;
#(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 64
) (
  input  logic                       clk_ref,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [level_wd(DEPTH)-1:0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned LVL_WD = level_wd(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LVL_WD-1:0] level_q;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (level_q == LVL_WD'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign level   = level_q;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage array, no reset needed.
  always_ff @(posedge clk_ref) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at the power-of-two depth; level tracks occupancy.
  always_ff @(posedge clk_ref) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LVL_WD'(1);
        2'b01:   level_q <= level_q - LVL_WD'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/ddr3_wr_packer.sv
// Packs 16-bit samples into 128-bit words for the DDR3 controller write port,
// pads every frame to whole bursts and issues a load pulse at each frame start.
// Build option: DDR3_WR_PACK_LANE_SWAP_EN reverses lane order (sample 0 in the top lane).
module ddr3_wr_packer
  import ddr3_pkg::*;
#(
  parameter int unsigned DATA_WD     = WR_DATA_WD,
  parameter int unsigned DQ_WIDTH    = WR_DQ_WIDTH,
  parameter int unsigned BURST_WORDS = WR_BURST_WORDS,
  parameter int unsigned FIFO_DEPTH  = WR_FIFO_DEPTH
) (
  input logic             clk_ref,
  input logic             rst_n,
  ddr3_wr_packer_if.slave bus
);

  localparam int unsigned WORD_WD = 8 * DQ_WIDTH;
  localparam int unsigned LANES   = WORD_WD / DATA_WD;
  localparam int unsigned LANE_W  = $clog2(LANES);
  localparam int unsigned BCNT_W  = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
  localparam int unsigned LVL_WD  = level_wd(FIFO_DEPTH);

  wr_state_e          state;
  wr_state_e          state_nxt;
  logic [LANE_W-1:0]  lane;
  logic [LANE_W-1:0]  lane_pos;
  logic [BCNT_W-1:0]  burst_cnt;
  logic [WORD_WD-1:0] word_buf;
  logic [WORD_WD-1:0] word_ins;
  logic [WORD_WD-1:0] push_data;
  logic [WORD_WD-1:0] fifo_dout;
  logic [LVL_WD-1:0]  level;
  logic               sof_seen;
  logic               sof_pend;
  logic               load_q;
  logic               err_sof_q;
  logic               err_udf_q;
  logic               push;
  logic               accept;
  logic               sof_block;
  logic               lane_last;
  logic               set_sof_err;
  logic               s_ready_c;
  logic               fifo_full;
  logic               fifo_empty;

  assign lane_last = (lane == LANE_W'(LANES - 1));
  assign sof_block = bus.s_valid && bus.s_sof && !sof_seen;

`ifdef DDR3_WR_PACK_LANE_SWAP_EN
  assign lane_pos = LANE_W'(LANES - 1) - lane;
`else
  assign lane_pos = lane;
`endif

  // Current partial word with the incoming sample dropped into its lane.
  always_comb begin
    word_ins = word_buf;
    for (int i = 0; i < LANES; i++) begin
      if (lane_pos == LANE_W'(i)) word_ins[i*DATA_WD +: DATA_WD] = bus.s_data;
    end
  end

  // Next-state, sample acceptance and FIFO push selection.
  always_comb begin
    state_nxt   = state;
    s_ready_c   = 1'b0;
    accept      = 1'b0;
    push        = 1'b0;
    push_data   = '0;
    set_sof_err = 1'b0;
    case (state)
      PACK: begin
        s_ready_c = !(lane_last && fifo_full) && !sof_block;
        accept    = bus.s_valid && s_ready_c;
        if (sof_block) begin
          if (lane != '0) begin
            set_sof_err = 1'b1;
            state_nxt   = PADW;
          end else begin
            state_nxt = DRAIN;
          end
        end else if (accept) begin
          if (lane_last) begin
            push      = 1'b1;
            push_data = word_ins;
          end
          if (bus.s_eof) state_nxt = lane_last ? PADB : PADW;
        end
      end
      PADW: begin
        if (!fifo_full) begin
          push      = 1'b1;
          push_data = word_buf;
          state_nxt = PADB;
        end
      end
      PADB: begin
        if (burst_cnt != '0) begin
          push = !fifo_full;
        end else begin
          state_nxt = sof_pend ? DRAIN : PACK;
        end
      end
      DRAIN: begin
        if (level == '0) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = PACK;
      end
      default: begin
        state_nxt = PACK;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_ref) begin
    if (!rst_n) state <= PACK;
    else        state <= state_nxt;
  end

  // Lane shift register, burst counter, frame-start tracking and sticky errors.
  always_ff @(posedge clk_ref) begin
    if (!rst_n) begin
      lane      <= '0;
      burst_cnt <= '0;
      word_buf  <= '0;
      sof_seen  <= 1'b0;
      sof_pend  <= 1'b0;
      load_q    <= 1'b0;
      err_sof_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      load_q <= (state_nxt == LOAD);
      if (accept) begin
        word_buf <= lane_last ? '0 : word_ins;
        lane     <= lane + LANE_W'(1);
        if (bus.s_sof) sof_seen <= 1'b0;
      end
      if ((state == PADW) && push) begin
        word_buf <= '0;
        lane     <= '0;
      end
      if (push) begin
        burst_cnt <= (burst_cnt == BCNT_W'(BURST_WORDS - 1)) ? '0 : burst_cnt + BCNT_W'(1);
      end
      if ((state_nxt == LOAD) && (state != LOAD)) sof_seen <= 1'b1;
      if (set_sof_err)         sof_pend <= 1'b1;
      else if (state == LOAD)  sof_pend <= 1'b0;
      if (set_sof_err) err_sof_q <= 1'b1;
      if (bus.ddr3_wr_ack && fifo_empty) err_udf_q <= 1'b1;
    end
  end

  ddr3_wr_fifo #(
    .WIDTH (WORD_WD),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_ref (clk_ref),
    .rst_n   (rst_n),
    .push    (push),
    .din     (push_data),
    .pop     (bus.ddr3_wr_ack),
    .dout    (fifo_dout),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.s_ready       = s_ready_c;
  assign bus.ddr3_din      = fifo_dout;
  assign bus.fifo_level    = level;
  assign bus.ddr3_wr_req   = (level >= LVL_WD'(BURST_WORDS));
  assign bus.ddr3_wr_load  = load_q;
  assign bus.err_sof_mid   = err_sof_q;
  assign bus.err_underflow = err_udf_q;

endmodule

// File: tb/tb_ddr3_wr_packer.sv
// Directed bench for ddr3_wr_packer. Define DDR3_WR_PACK_LANE_SWAP_EN to check
// the reversed lane order build.
module tb_ddr3_wr_packer;

`ifdef DDR3_WR_PACK_LANE_SWAP_EN
  localparam logic [127:0] T1_W0 = 128'h0000_0001_0002_0003_0004_0005_0006_0007;
  localparam logic [127:0] T2_W2 = 128'h0010_0011_0012_0013_0000_0000_0000_0000;
  localparam logic [127:0] T4_W0 = 128'hA000_A001_A002_0000_0000_0000_0000_0000;
`else
  localparam logic [127:0] T1_W0 = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
  localparam logic [127:0] T2_W2 = 128'h0000_0000_0000_0000_0013_0012_0011_0010;
  localparam logic [127:0] T4_W0 = 128'h0000_0000_0000_0000_0000_A002_A001_A000;
`endif
  localparam int ACCEPT_LIMIT = 200;

  logic clk_ref = 1'b0;
  logic rst_n   = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   load_cnt = 0;
  int   req_rises = 0;
  logic req_q = 1'b0;
  int   l0;

  always #5 clk_ref = ~clk_ref;

  ddr3_wr_packer_if bus ();

  ddr3_wr_packer dut (
    .clk_ref (clk_ref),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  // Event counters for load pulses and req rising edges.
  always @(posedge clk_ref) begin
    req_q <= bus.ddr3_wr_req;
    if (bus.ddr3_wr_load) load_cnt <= load_cnt + 1;
    if (bus.ddr3_wr_req && !req_q) req_rises <= req_rises + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%032h expected=%032h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_word(input logic [15:0] base, input int n);
    logic [127:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < n) begin
`ifdef DDR3_WR_PACK_LANE_SWAP_EN
        w[(7-k)*16 +: 16] = base + 16'(k);
`else
        w[k*16 +: 16] = base + 16'(k);
`endif
      end
    end
    return w;
  endfunction

  task automatic present(input logic [15:0] d, input logic sof, input logic eof);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_sof   = sof;
    bus.s_eof   = eof;
  endtask

  // Wait (bounded) for the presented sample to be taken, then drop valid.
  task automatic wait_accept();
    int n;
    n = 0;
    while (!bus.s_ready && n < ACCEPT_LIMIT) begin
      @(negedge clk_ref); #1;
      n++;
    end
    if (n >= ACCEPT_LIMIT) chk("accept_timeout", 32'(n), 32'(ACCEPT_LIMIT - 1));
    @(posedge clk_ref); #1;
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    bus.s_eof   = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic sof, input logic eof);
    @(negedge clk_ref);
    present(d, sof, eof);
    #1;
    wait_accept();
  endtask

  task automatic pop_chk(input string tag, input logic [127:0] exp);
    @(negedge clk_ref);
    bus.ddr3_wr_ack = 1'b1;
    #1;
    chk_w(tag, bus.ddr3_din, exp);
    @(posedge clk_ref); #1;
    bus.ddr3_wr_ack = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk_ref); rst_n = 1'b0;
    @(negedge clk_ref); rst_n = 1'b1;
    #1;
  endtask

  initial begin
    bus.s_valid     = 1'b0;
    bus.s_data      = '0;
    bus.s_sof       = 1'b0;
    bus.s_eof       = 1'b0;
    bus.ddr3_wr_ack = 1'b0;
    repeat (3) @(negedge clk_ref);
    rst_n = 1'b1;
    #1;
    chk("rst_level", 32'(bus.fifo_level), 0);
    chk("rst_req", 32'(bus.ddr3_wr_req), 0);
    chk("rst_load", 32'(bus.ddr3_wr_load), 0);
    chk_w("rst_din", bus.ddr3_din, '0);
    chk("rst_err_sof", 32'(bus.err_sof_mid), 0);
    chk("rst_err_udf", 32'(bus.err_underflow), 0);

    // Test 1: 128-sample frame -> 16 words, one load pulse.
    send(16'd0, 1'b1, 1'b0);
    for (int i = 1; i < 128; i++) send(16'(i), 1'b0, (i == 127));
    repeat (3) @(negedge clk_ref); #1;
    chk("t1_load_cnt", 32'(load_cnt), 1);
    chk("t1_level", 32'(bus.fifo_level), 16);
    chk("t1_req", 32'(bus.ddr3_wr_req), 1);
    chk_w("t1_word0_const", bus.ddr3_din, T1_W0);
    for (int w = 0; w < 16; w++) pop_chk($sformatf("t1_word%0d", w), exp_word(16'(8*w), 8));
    @(negedge clk_ref); #1;
    chk("t1_level_drained", 32'(bus.fifo_level), 0);
    chk("t1_req_low", 32'(bus.ddr3_wr_req), 0);

    // Test 2: 20-sample frame -> partial word plus 13 pad words.
    send(16'd0, 1'b1, 1'b0);
    for (int i = 1; i < 20; i++) send(16'(i), 1'b0, (i == 19));
    repeat (20) @(negedge clk_ref); #1;
    chk("t2_load_cnt", 32'(load_cnt), 2);
    chk("t2_level", 32'(bus.fifo_level), 16);
    chk("t2_req_rises", 32'(req_rises), 2);
    pop_chk("t2_word0", exp_word(16'd0, 8));
    pop_chk("t2_word1", exp_word(16'd8, 8));
    pop_chk("t2_word2_const", T2_W2);
    for (int w = 3; w < 16; w++) pop_chk($sformatf("t2_pad%0d", w), '0);
    @(negedge clk_ref); #1;
    chk("t2_level_drained", 32'(bus.fifo_level), 0);

    // Test 3: backpressure with no acks until the FIFO saturates.
    for (int i = 0; i < 519; i++) send(16'(i), 1'b0, 1'b0);
    @(negedge clk_ref);
    present(16'd519, 1'b0, 1'b0);
    #1;
    chk("t3_ready_full", 32'(bus.s_ready), 0);
    chk("t3_level_full", 32'(bus.fifo_level), 64);
    chk("t3_req_full", 32'(bus.ddr3_wr_req), 1);
    repeat (2) @(negedge clk_ref); #1;
    chk("t3_ready_held", 32'(bus.s_ready), 0);
    pop_chk("t3_word0", exp_word(16'd0, 8));
    @(negedge clk_ref); #1;
    chk("t3_ready_resume", 32'(bus.s_ready), 1);
    wait_accept();
    @(negedge clk_ref); #1;
    chk("t3_level_refill", 32'(bus.fifo_level), 64);
    for (int w = 1; w < 65; w++) pop_chk($sformatf("t3_word%0d", w), exp_word(16'(8*w), 8));
    @(negedge clk_ref); #1;
    chk("t3_level_drained", 32'(bus.fifo_level), 0);

    // Test 4: SOF arriving mid-word forces padding, drain and a fresh load.
    pulse_reset();
    l0 = load_cnt;
    send(16'hA000, 1'b1, 1'b0);
    send(16'hA001, 1'b0, 1'b0);
    send(16'hA002, 1'b0, 1'b0);
    chk("t4_load_first", 32'(load_cnt), 32'(l0 + 1));
    @(negedge clk_ref);
    present(16'hB000, 1'b1, 1'b0);
    repeat (24) @(negedge clk_ref); #1;
    chk("t4_err_sof", 32'(bus.err_sof_mid), 1);
    chk("t4_level", 32'(bus.fifo_level), 16);
    chk("t4_ready_blocked", 32'(bus.s_ready), 0);
    chk("t4_no_early_load", 32'(load_cnt), 32'(l0 + 1));
    pop_chk("t4_word0_const", T4_W0);
    for (int w = 1; w < 16; w++) pop_chk($sformatf("t4_pad%0d", w), '0);
    wait_accept();
    chk("t4_load_second", 32'(load_cnt), 32'(l0 + 2));
    for (int i = 1; i < 8; i++) send(16'hB000 + 16'(i), 1'b0, 1'b0);
    @(negedge clk_ref); #1;
    chk("t4_level_new", 32'(bus.fifo_level), 1);
    pop_chk("t4_new_word", exp_word(16'hB000, 8));

    // Test 5: underflow, then reset mid-burst.
    @(negedge clk_ref);
    bus.ddr3_wr_ack = 1'b1;
    @(posedge clk_ref); #1;
    bus.ddr3_wr_ack = 1'b0;
    @(negedge clk_ref); #1;
    chk("t5_err_udf", 32'(bus.err_underflow), 1);
    chk("t5_level_udf", 32'(bus.fifo_level), 0);
    for (int i = 0; i < 132; i++) send(16'hC000 + 16'(i), 1'b0, 1'b0);
    @(negedge clk_ref); #1;
    chk("t5_req_pre", 32'(bus.ddr3_wr_req), 1);
    l0 = load_cnt;
    pulse_reset();
    chk("t5_rst_level", 32'(bus.fifo_level), 0);
    chk("t5_rst_req", 32'(bus.ddr3_wr_req), 0);
    chk("t5_rst_err_sof", 32'(bus.err_sof_mid), 0);
    chk("t5_rst_err_udf", 32'(bus.err_underflow), 0);
    chk_w("t5_rst_din", bus.ddr3_din, '0);
    send(16'hD000, 1'b1, 1'b0);
    @(negedge clk_ref); #1;
    chk("t5_load_after_rst", 32'(load_cnt), 32'(l0 + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
